// File: rtl/hilo_mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: MDU op codes,
// op field width and FSM state encoding.
package hilo_mdu_pkg;

  localparam int unsigned MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_ITER = 2'd1,
    MDS_FIX  = 2'd2
  } mds_state_e;

endpackage

// File: rtl/hilo_mdu_if.sv
// Decoder <-> MDU bus: op issue handshake, flush, status and HI/LO readout.
interface hilo_mdu_if #(
  parameter int unsigned WIDTH = 32
);
  import hilo_mdu_pkg::*;

  logic                 op_valid;
  logic [MD_OP_W-1:0]   op;
  logic [WIDTH-1:0]     src_a;
  logic [WIDTH-1:0]     src_b;
  logic                 flush;
  logic                 op_ready;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  op_ready, busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output op_ready, busy, done, hi, lo
  );

endinterface

// File: rtl/hilo_mdu_divstep.sv
// One combinational radix-2 restoring division step.
module mdu_divstep #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_dvd_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  // Shift in the next dividend bit and subtract if the divisor fits.
  always_comb begin
    w_shift = {i_rem, i_dvd_bit};
    w_diff  = w_shift - {2'b00, i_divisor};
    o_qbit  = ~w_diff[WIDTH+1];
    o_rem   = o_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
  end

endmodule

// File: rtl/hilo_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle MULT/MULTU).
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  hilo_mdu_if.slave mdu
);

  localparam int unsigned CW = $clog2(WIDTH);

  mds_state_e         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_div0;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_op_ready;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_rem;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_remf;

  assign mdu.op_ready = r_op_ready;
  assign mdu.busy     = r_busy;
  assign mdu.done     = r_done;
  assign mdu.hi       = r_hi;
  assign mdu.lo       = r_lo;

  // Operand magnitudes and sign bookkeeping at issue.
  always_comb begin
    w_accept = mdu.op_valid && r_op_ready && !mdu.flush;
    w_signed = (mdu.op == MD_MULT) || (mdu.op == MD_DIV);
    w_sa     = w_signed & mdu.src_a[WIDTH-1];
    w_sb     = w_signed & mdu.src_b[WIDTH-1];
    w_mag_a  = w_sa ? -mdu.src_a : mdu.src_a;
    w_mag_b  = w_sb ? -mdu.src_b : mdu.src_b;
  end

  // Shift-add step: low half of r_acc holds remaining multiplier bits.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                 (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  end

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .i_rem     (r_rem),
    .i_dvd_bit (r_acc[WIDTH-1]),
    .i_divisor (r_opnd),
    .o_rem     (w_div_rem),
    .o_qbit    (w_qbit)
  );

  // Sign correction applied in FIX.
  always_comb begin
    w_prod = r_neg_res ? -r_acc : r_acc;
    w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_remf = r_neg_rem ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;

  // Full-width product; sign extension makes one multiplier serve both signednesses.
  always_comb begin
    w_fast_prod = {{WIDTH{w_sa & w_signed}}, mdu.src_a} *
                  {{WIDTH{w_sb & w_signed}}, mdu.src_b};
  end
`endif

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= MDS_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div0     <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_op_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (mdu.flush) begin
      r_state    <= MDS_IDLE;
      r_cnt      <= '0;
      r_op_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MDS_IDLE: begin
          if (w_accept) begin
            case (mdu.op)
              MD_MTHI: r_hi <= mdu.src_a;
              MD_MTLO: r_lo <= mdu.src_a;
              MD_MULT, MD_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                r_hi   <= w_fast_prod[2*WIDTH-1:WIDTH];
                r_lo   <= w_fast_prod[WIDTH-1:0];
                r_done <= 1'b1;
`else
                r_state    <= MDS_ITER;
                r_cnt      <= '0;
                r_is_div   <= 1'b0;
                r_neg_res  <= w_sa ^ w_sb;
                r_neg_rem  <= 1'b0;
                r_div0     <= 1'b0;
                r_opnd     <= w_mag_a;
                r_acc      <= {{WIDTH{1'b0}}, w_mag_b};
                r_busy     <= 1'b1;
                r_op_ready <= 1'b0;
`endif
              end
              MD_DIV, MD_DIVU: begin
                r_state    <= MDS_ITER;
                r_cnt      <= '0;
                r_is_div   <= 1'b1;
                r_neg_res  <= w_sa ^ w_sb;
                r_neg_rem  <= w_sa;
                r_div0     <= (mdu.src_b == '0);
                r_opnd     <= w_mag_b;
                r_acc      <= {{WIDTH{1'b0}}, w_mag_a};
                r_rem      <= '0;
                r_busy     <= 1'b1;
                r_op_ready <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        MDS_ITER: begin
          if (r_is_div) begin
            r_rem              <= w_div_rem;
            r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_qbit};
          end else begin
            r_acc <= w_mul_next;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= MDS_FIX;
        end
        MDS_FIX: begin
          // Divide by zero leaves the magnitude dividend as remainder, so HI
          // already equals src_a after sign restore; only LO needs forcing.
          if (r_is_div) begin
            r_hi <= w_remf;
            r_lo <= r_div0 ? '1 : w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_op_ready <= 1'b1;
          r_state    <= MDS_IDLE;
        end
        default: r_state <= MDS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu.
module tb_hilo_mdu;
  import hilo_mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hilo_mdu_if #(.WIDTH(32)) bus ();

  hilo_mdu #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op in cycle 0, then wait (bounded) for done and check results.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat);
    int cyc;
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
    tick();
    bus.op_valid = 1'b0;
    cyc = 1;
    if (lat > 1) check({tag, " busy@1"}, 64'(bus.busy), 64'd1);
    while (bus.done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " hi"}, 64'(bus.hi), 64'(ehi));
    check({tag, " lo"}, 64'(bus.lo), 64'(elo));
    check({tag, " op_ready@done"}, 64'(bus.op_ready), 64'd1);
    tick();
    check({tag, " done one cycle"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int cyc;
    int n_done;
    int n_busy_bad;
    bus.op_valid = 1'b0;
    bus.op       = '0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.flush    = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset op_ready", 64'(bus.op_ready), 64'd1);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);

    // MTHI / MTLO visible in cycle 1, no done
    bus.op_valid = 1'b1; bus.op = MD_MTHI; bus.src_a = 32'h1234_5678;
    tick();
    bus.op_valid = 1'b0;
    check("mthi hi", 64'(bus.hi), 64'h1234_5678);
    check("mthi done", 64'(bus.done), 64'd0);
    check("mthi op_ready", 64'(bus.op_ready), 64'd1);
    bus.op_valid = 1'b1; bus.op = MD_MTLO; bus.src_a = 32'hCAFE_F00D;
    tick();
    bus.op_valid = 1'b0;
    check("mtlo lo", 64'(bus.lo), 64'hCAFE_F00D);
    check("mtlo hi kept", 64'(bus.hi), 64'h1234_5678);

    // flush blocks a simultaneous accept
    bus.op_valid = 1'b1; bus.op = MD_MTHI; bus.src_a = 32'hDEAD_BEEF; bus.flush = 1'b1;
    tick();
    bus.op_valid = 1'b0; bus.flush = 1'b0;
    check("flushed mthi hi", 64'(bus.hi), 64'h1234_5678);

    // no-op encodings leave HI/LO alone
    bus.op_valid = 1'b1; bus.op = 3'd7; bus.src_a = 32'h5555_5555;
    tick();
    bus.op_valid = 1'b0;
    check("nop busy", 64'(bus.busy), 64'd0);
    check("nop lo", 64'(bus.lo), 64'hCAFE_F00D);

    run_op("mult -1x2",   MD_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("multu max x2", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mult 7x-3",   MD_MULT,  32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
    run_op("multu big",   MD_MULTU, 32'h8000_0001, 32'h0000_0010, 32'h0000_0008, 32'h0000_0010, MUL_LAT);
    run_op("div -7/2",    MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    run_op("div 7/-2",    MD_DIV,   32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT);
    run_op("div min/-1",  MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT);
    run_op("divu 100/7",  MD_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
    run_op("divu 100/0",  MD_DIVU,  32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, DIV_LAT);
    run_op("div -100/0",  MD_DIV,   32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, DIV_LAT);

    // flush in cycle 10 of a DIVU
    bus.op_valid = 1'b1; bus.op = MD_DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    tick();
    bus.op_valid = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush10 op_ready", 64'(bus.op_ready), 64'd1);
    check("flush10 busy", 64'(bus.busy), 64'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) n_done++;
      tick();
    end
    check("flush10 no done", 64'(n_done), 64'd0);
    check("flush10 hi", 64'(bus.hi), 64'hFFFF_FF9C);
    check("flush10 lo", 64'(bus.lo), 64'hFFFF_FFFF);

    // flush in the FIX cycle (33) suppresses the write
    bus.op_valid = 1'b1; bus.op = MD_DIVU; bus.src_a = 32'd9; bus.src_b = 32'd4;
    tick();
    bus.op_valid = 1'b0;
    for (int i = 1; i < 33; i++) tick();
    check("fix busy@33", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fixflush done", 64'(bus.done), 64'd0);
    check("fixflush hi", 64'(bus.hi), 64'hFFFF_FF9C);
    check("fixflush lo", 64'(bus.lo), 64'hFFFF_FFFF);
    check("fixflush op_ready", 64'(bus.op_ready), 64'd1);

    // op_valid held through busy: second accept only at cycle 34
    bus.op_valid = 1'b1; bus.op = MD_DIVU; bus.src_a = 32'd50; bus.src_b = 32'd5;
    tick();
    cyc = 1;
    n_busy_bad = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy !== 1'b1 || bus.op_ready !== 1'b0) n_busy_bad++;
      tick();
      cyc++;
    end
    check("held busy 1..33", 64'(n_busy_bad), 64'd0);
    check("held first latency", 64'(cyc), 64'd34);
    check("held first lo", 64'(bus.lo), 64'd10);
    check("held first hi", 64'(bus.hi), 64'd0);
    tick();
    bus.op_valid = 1'b0;
    check("held second accepted", 64'(bus.busy), 64'd1);
    cyc = 35;
    while (bus.done !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
    check("held second latency", 64'(cyc), 64'd68);
    check("held second lo", 64'(bus.lo), 64'd10);

    // reset overrides an in-flight op
    bus.op_valid = 1'b1; bus.op = MD_DIV; bus.src_a = 32'd77; bus.src_b = 32'd7;
    tick();
    bus.op_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midop reset busy", 64'(bus.busy), 64'd0);
    check("midop reset hi", 64'(bus.hi), 64'd0);
    check("midop reset lo", 64'(bus.lo), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
